// File: rtl/pcie_tl_pkg.sv
// Shared definitions for the PCIe transaction-layer datapath:
// arbiter FSM encodings, virtual-channel identifiers and default word geometry.
package pcie_tl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  localparam logic VC0_ID = 1'b0;
  localparam logic VC1_ID = 1'b1;

  localparam int DEF_DATA_W   = 6;
  localparam int DEF_DEST_BIT = 4;

endpackage

// File: rtl/vc_arb_grant.sv
// Grant selector for the two virtual channels: fixed VC0 priority with a
// burst limit that hands one grant to VC1 after MAX_BURST back-to-back VC0
// grants while VC1 is waiting. Pops are combinational; burst_cnt is registered.
module vc_arb_grant
  import pcie_tl_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic empty_vc0,
  input  logic empty_vc1,
  output logic pop_vc0,
  output logic pop_vc1
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

  logic [BW-1:0] burst_cnt;

  // Priority select: starved VC1 first, then VC0, then VC1; never pop an empty FIFO
  always_comb begin
    pop_vc0 = 1'b0;
    pop_vc1 = 1'b0;
    if (grant_en) begin
      if ((burst_cnt == BURST_LIMIT) && !empty_vc1) begin
        pop_vc1 = 1'b1;
      end else if (!empty_vc0) begin
        pop_vc0 = 1'b1;
      end else if (!empty_vc1) begin
        pop_vc1 = 1'b1;
      end
    end
  end

  // Count consecutive VC0 grants only while VC1 has something waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
    end else if (pop_vc1) begin
      burst_cnt <= '0;
    end else if (pop_vc0) begin
      burst_cnt <= empty_vc1 ? '0 : burst_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// Moves words from the VC0/VC1 FIFOs to the D0/D1 FIFOs. A three-state FSM
// gates popping on link activity and destination back-pressure; a two-stage
// pipeline (pop -> FIFO read data -> push) routes each word by its DEST_BIT.
module vc_arbiter
  import pcie_tl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEST_BIT  = DEF_DEST_BIT,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              empty_VC0,
  input  logic              empty_VC1,
  input  logic [DATA_W-1:0] data_VC0,
  input  logic [DATA_W-1:0] data_VC1,
  input  logic              almost_full_D0,
  input  logic              almost_full_D1,
  output logic              pop_VC0,
  output logic              pop_VC1,
  output logic              push_D0,
  output logic              push_D1,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count_D0,
  output logic [CNT_W-1:0]  count_D1,
  output logic [1:0]        arb_state,
  output logic              idle_out
);

  arb_state_t state_reg;
  arb_state_t state_next;
  logic af;
  logic any;
  logic grant_en;
  logic popping;
  logic v1_reg;
  logic vc1_reg;
  logic [DATA_W-1:0] word;
  logic [1:0] push_vec;
  logic [1:0][CNT_W-1:0] cnt_reg;

  function automatic arb_state_t fsm_next(input arb_state_t cur, input logic act,
                                          input logic any_w, input logic af_w);
    arb_state_t nxt;
    nxt = cur;
    case (cur)
      ST_IDLE: if (act && any_w) nxt = af_w ? ST_HOLD : ST_RUN;
      ST_RUN: begin
        if (af_w) nxt = ST_HOLD;
        else if (!act || !any_w) nxt = ST_IDLE;
      end
      ST_HOLD: begin
        if (!act) nxt = ST_IDLE;
        else if (!af_w) nxt = ST_RUN;
      end
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  // Either destination nearing full blocks all pops (head-of-line blocking)
  assign af         = almost_full_D0 | almost_full_D1;
  assign any        = !empty_VC0 | !empty_VC1;
  assign grant_en   = (state_reg == ST_RUN) && active_in && !af;
  assign popping    = pop_VC0 | pop_VC1;
  assign state_next = fsm_next(state_reg, active_in, any, af);
  assign arb_state  = state_reg;
  assign word       = (vc1_reg == VC1_ID) ? data_VC1 : data_VC0;

  vc_arb_grant #(
    .MAX_BURST(MAX_BURST)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .grant_en (grant_en),
    .empty_vc0(empty_VC0),
    .empty_vc1(empty_VC1),
    .pop_vc0  (pop_VC0),
    .pop_vc1  (pop_VC1)
  );

  // FSM state plus idle flag (idle once next state is IDLE with nothing left to push)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      idle_out  <= 1'b1;
    end else begin
      state_reg <= state_next;
      idle_out  <= (state_next == ST_IDLE) && !popping && !v1_reg;
    end
  end

  // Two-stage pipeline: remember the pop, then capture FIFO data and push it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_reg   <= 1'b0;
      vc1_reg  <= VC0_ID;
      push_D0  <= 1'b0;
      push_D1  <= 1'b0;
      data_out <= '0;
    end else begin
      v1_reg <= popping;
      if (popping) begin
        vc1_reg <= pop_VC1 ? VC1_ID : VC0_ID;
      end
      push_D0 <= v1_reg && (word[DEST_BIT] == 1'b0);
      push_D1 <= v1_reg && (word[DEST_BIT] == 1'b1);
      if (v1_reg) begin
        data_out <= word;
      end
    end
  end

  assign push_vec = {push_D1, push_D0};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      // Saturating count of pushes into this destination
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else if (push_vec[gi] && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign cnt_reg[gi] = cnt_q;
    end
  endgenerate

  assign count_D0 = cnt_reg[0];
  assign count_D1 = cnt_reg[1];

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the PCIe transaction-layer datapath. It pops words from VC0/VC1 under fixed priority with anti-starvation, routes each word to D0 or D1 by its destination bit, and honours back-pressure from the destination FIFOs. It runs only while the top-level state machine reports the link active.

## Interface
Parameters:
- DATA_W, 6: word width of all FIFOs.
- DEST_BIT, 4: index of the destination bit in the word (0 → D0, 1 → D1).
- MAX_BURST, 4: maximum consecutive VC0 grants while VC1 is non-empty.
- CNT_W, 8: width of the per-destination push counters.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- active_in  in  1  from the top-level state machine; high enables new pops.
- empty_VC0, empty_VC1  in  1  VC FIFO empty flags (updated at the same edge as a pop).
- data_VC0, data_VC1  in  DATA_W  VC FIFO read data, valid the cycle after pop.
- almost_full_D0, almost_full_D1  in  1  destination back-pressure; asserted with ≥2 free entries.
- pop_VC0, pop_VC1  out  1  combinational read strobes.
- push_D0, push_D1  out  1  registered write strobes.
- data_out  out  DATA_W  registered word to D0/D1.
- count_D0, count_D1  out  CNT_W  saturating push counters.
- arb_state  out  2  current FSM state (debug).
- idle_out  out  1  registered; high in IDLE with an empty pipeline.

## Operation
- FSM states: IDLE=0, RUN=1, HOLD=2. Let af = almost_full_D0 | almost_full_D1 and any = !empty_VC0 | !empty_VC1.
- IDLE → RUN when active_in & any & !af. IDLE → HOLD when active_in & any & af.
- RUN → HOLD when af. RUN → IDLE when !active_in or !any. Otherwise, stay in RUN.
- HOLD → IDLE when !active_in. HOLD → RUN when !af & active_in.
- Grant selection happens only in RUN, and only when active_in & !af:
  - VC1 wins if burst_cnt == MAX_BURST and !empty_VC1.
  - Otherwise VC0 wins if !empty_VC0.
  - Otherwise VC1 wins if !empty_VC1.
- pop_VCx is high for the granted VC only. Pops are never issued to an empty FIFO, and never both in one cycle.
- burst_cnt (width clog2(MAX_BURST+1)) updates as follows:
  - VC0 grant with !empty_VC1: increment.
  - VC0 grant with empty_VC1: clear to 0.
  - Any VC1 grant: clear to 0.
  - No grant: hold.
- Pipeline stage 1: on a pop, register v1=1 and vc1=granted VC.
- Pipeline stage 2: when v1=1, capture data_out = vc1 ? data_VC1 : data_VC0, and assert exactly one of push_D0/push_D1 for one cycle, selected by data_out[DEST_BIT].
- Back-pressure is conservative head-of-line blocking: either almost-full stalls all pops. In-flight words (at most 2) always complete.
- Dropping active_in mid-burst stops new pops immediately; in-flight words still push.
- count_Dx increments on each push_Dx and saturates at 2^CNT_W−1.
- idle_out = registered (next state is IDLE & pipeline empty).

## Timing
- Reset values: arb_state=IDLE; push_D0, push_D1, data_out, count_D0, count_D1, burst_cnt, v1 all 0; idle_out=1.
- Latency: pop asserted in cycle N → push_Dx and data_out valid in cycle N+2.
- Throughput: one word per cycle in RUN.
- A pop issued in the same cycle af rises is still allowed only if af was low that cycle. af is sampled combinationally, so the pop is blocked in that cycle.
- Reset asserted mid-transfer discards in-flight words with no push. The next pop occurs no earlier than 1 cycle after reset release.

## Structure
- Shared package pcie_tl_pkg holds the FSM state encodings (IDLE/RUN/HOLD), the VC id constants, and the default DATA_W/DEST_BIT.
- One sub-module: vc_arb_grant, the combinational priority/anti-starvation selector plus the burst_cnt register. The FSM and pipeline stay in the top module.

## Test plan
- VC0 holds 3 words with DEST_BIT values 0, 1, 0; VC1 empty; active_in=1 → pops in cycles 1–3; push_D0, push_D1, push_D0 in cycles 3–5 with matching data; count_D0=2, count_D1=1.
- Both VCs hold 10 words, MAX_BURST=4 → grant order VC0×4, VC1, VC0×4, VC1…; burst_cnt never exceeds 4.
- almost_full_D1 rises mid-stream → pops stop that cycle; FSM goes to HOLD; at most 2 trailing pushes occur. Deasserting it → RUN, and pops resume the next cycle.
- active_in drops with 2 words in flight → no new pops; both pushes complete; FSM reaches IDLE; idle_out=1 two cycles later.
- Async reset pulse between a pop and its push → no push occurs; all outputs read their reset values immediately.
- 2^CNT_W+3 words to D0 → count_D0 saturates at 255 (CNT_W=8) and stays there.
